// File: rtl/mdu_pkg.sv
// Shared types for the MDU sequencing controller: E-stage op classes,
// datapath op codes and controller states.
package mdu_pkg;

    localparam int MDU_CNT_W = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_HILO  = 3'd5,
        MD_MADD  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    // Only the four issuable classes map to a datapath op; anything else is don't-care.
    function automatic mdu_op_t to_mdu_op(input md_op_t op);
        case (op)
            MD_MULTU: to_mdu_op = MDU_MULTU;
            MD_DIV:   to_mdu_op = MDU_DIV;
            MD_DIVU:  to_mdu_op = MDU_DIVU;
            default:  to_mdu_op = MDU_MULT;
        endcase
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl.sv
// Issues mult/div ops to the MDU datapath, counts their fixed latency, signals
// the {hi,lo} write and holds the D stage while a HI/LO consumer would race it.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] md_op_e,
    input  logic       divisor_zero_e,
    input  logic       hilo_use_d,
    input  logic       int_req,
    output logic       mdu_start,
    output logic [1:0] mdu_op,
    output logic       mdu_commit,
    output logic       mdu_done,
    output logic       busy,
    output logic       stall_d,
    output logic       conflict
);

    if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul
        $error("mdu_seq_ctrl: MUL_CYCLES must be in 2..15");
    end
    if (DIV_CYCLES < 2 || DIV_CYCLES > 15) begin : g_bad_div
        $error("mdu_seq_ctrl: DIV_CYCLES must be in 2..15");
    end

    localparam logic [MDU_CNT_W-1:0] MUL_N = MDU_CNT_W'(MUL_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_N = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_t           state, state_nxt;
    logic [MDU_CNT_W-1:0] cnt, cnt_nxt;
    mdu_op_t              op_q, op_nxt;
    logic                 dz_q, dz_nxt;
    logic                 conflict_q;

    md_op_t op_e;
    logic   is_mdu_op, is_div_op;
    logic   issue, done, commit;

    assign op_e      = md_op_t'(md_op_e);
    assign is_mdu_op = (op_e == MD_MULT) || (op_e == MD_MULTU) ||
                       (op_e == MD_DIV)  || (op_e == MD_DIVU);
    assign is_div_op = (op_e == MD_DIV)  || (op_e == MD_DIVU);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        dz_nxt    = dz_q;
        issue     = 1'b0;
        done      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                // int_req flushes E, so a flushed op must never reach the datapath.
                if (is_mdu_op && !int_req) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = is_div_op ? DIV_N : MUL_N;
                    op_nxt    = to_mdu_op(op_e);
                    dz_nxt    = divisor_zero_e && is_div_op;
                end
            end
            RUN: begin
                // Ops arriving now are ignored; an issued op always runs to completion.
                if (cnt == MDU_CNT_W'(1)) begin
                    done      = 1'b1;
                    commit    = !dz_q;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - MDU_CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= MDU_MULT;
            dz_q       <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_q       <= op_nxt;
            dz_q       <= dz_nxt;
            conflict_q <= (busy && (op_e != MD_NONE)) || (int_req && commit);
        end
    end

    assign busy       = (state == RUN);
    assign mdu_op     = op_q;
    assign conflict   = conflict_q;
    assign mdu_start  = issue && !reset;
    assign mdu_done   = done && !reset;
    assign mdu_commit = commit && !reset;
    // Held through the commit cycle so the consumer reads the freshly written HI/LO.
    assign stall_d    = hilo_use_d && (busy || issue) && !reset;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Randomized bench for mdu_seq_ctrl: a cycle-numbered reference model predicts
// per-cycle outputs and queues each issued op's completion for a separate monitor.
module tb_mdu_seq_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] md_op_e;
    logic       divisor_zero_e;
    logic       hilo_use_d;
    logic       int_req;
    logic       mdu_start;
    logic [1:0] mdu_op;
    logic       mdu_commit;
    logic       mdu_done;
    logic       busy;
    logic       stall_d;
    logic       conflict;

    mdu_seq_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .md_op_e(md_op_e), .divisor_zero_e(divisor_zero_e),
        .hilo_use_d(hilo_use_d), .int_req(int_req), .mdu_start(mdu_start),
        .mdu_op(mdu_op), .mdu_commit(mdu_commit), .mdu_done(mdu_done), .busy(busy),
        .stall_d(stall_d), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       due;
        bit [1:0] op;
        bit       commit;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Reference model state: the last issued op as absolute cycle numbers.
    bit active = 0;
    int issue_cyc = 0;
    int end_cyc = 0;
    bit dz_m = 0;
    bit conf_pend = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every completion the DUT reports must match the oldest queued op.
    always @(negedge clk) begin
        if (mdu_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_without_issue", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("done_op", int'(mdu_op), int'(e.op));
                chk("done_commit", int'(mdu_commit), int'(e.commit));
            end
        end
    end

    // One clock cycle: apply inputs, predict, check at negedge, advance the model.
    task automatic step(input logic [2:0] op, input logic dz, input logic hu,
                        input logic irq, input logic rst);
        bit m_busy, m_issue, m_done, m_commit, is_div;
        md_op_e = op; divisor_zero_e = dz; hilo_use_d = hu; int_req = irq; reset = rst;
        is_div   = (op == 3'd3) || (op == 3'd4);
        m_busy   = active && (cyc > issue_cyc) && (cyc <= end_cyc);
        m_issue  = !m_busy && (op >= 3'd1) && (op <= 3'd4) && !irq && !rst;
        m_done   = m_busy && (cyc == end_cyc) && !rst;
        m_commit = m_done && !dz_m;
        @(negedge clk);
        chk("mdu_start", int'(mdu_start), int'(m_issue));
        chk("busy", int'(busy), int'(m_busy));
        chk("mdu_done", int'(mdu_done), int'(m_done));
        chk("mdu_commit", int'(mdu_commit), int'(m_commit));
        chk("stall_d", int'(stall_d), int'(hu && (m_busy || m_issue) && !rst));
        chk("conflict", int'(conflict), int'(conf_pend));
        if (rst) begin
            if (m_busy) void'(sb.pop_back());
            active = 0;
            conf_pend = 0;
        end else begin
            conf_pend = (m_busy && op != 3'd0) || (irq && m_commit);
            if (m_issue) begin
                active    = 1;
                issue_cyc = cyc;
                end_cyc   = cyc + (is_div ? DIV_N : MUL_N);
                dz_m      = dz && is_div;
                sb.push_back('{end_cyc, 2'(op - 3'd1), !(dz && is_div)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic hu);
        for (int i = 0; i < n; i++) step(3'd0, 1'b0, hu, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; md_op_e = '0; divisor_zero_e = 0; hilo_use_d = 0; int_req = 0;
        repeat (2) @(posedge clk);
        #1;
        step(3'd0, 0, 0, 0, 1);
        step(3'd0, 0, 1, 1, 1);
        idle(2, 0);
        // mult with defaults, then back-to-back multu right after commit
        step(3'd1, 0, 0, 0, 0);
        idle(5, 0);
        step(3'd2, 0, 0, 0, 0);
        idle(6, 0);
        // div by zero: done without commit
        step(3'd3, 1, 0, 0, 0);
        idle(11, 0);
        // divu with an mfhi waiting in D
        step(3'd4, 0, 1, 0, 0);
        idle(10, 1);
        idle(2, 0);
        // multu flushed by int_req
        step(3'd2, 0, 1, 1, 0);
        step(3'd0, 0, 1, 0, 0);
        idle(1, 0);
        // reset mid-div, then a normal mult
        step(3'd3, 0, 0, 0, 0);
        idle(2, 0);
        step(3'd0, 0, 0, 0, 1);
        idle(2, 0);
        step(3'd1, 0, 0, 0, 0);
        idle(6, 0);
        // op forced in while busy, then int_req on the commit cycle
        step(3'd3, 0, 0, 0, 0);
        step(3'd0, 0, 0, 0, 0);
        step(3'd1, 0, 0, 0, 0);
        step(3'd6, 0, 0, 0, 0);
        idle(6, 0);
        step(3'd0, 0, 0, 1, 0);
        idle(3, 0);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(1, 6));
            step(op, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 149) == 0));
        end
        idle(20, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
